// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between the CPU memory port and the
// program-loader/debug port. One access at a time runs through the FSM
// IDLE -> ACCESS -> [WAIT] -> DONE -> IDLE. The CPU normally wins, but a
// starvation counter hands the RAM to the loader after STARVE_MAX consecutive
// CPU grants taken while the loader was waiting.
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_WAIT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_LAST  = 3'(RD_WAIT - 1);

  state_t            state_q;
  logic              owner_q;
  logic [3:0]        starve_q;
  logic [2:0]        wait_cnt_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic              ram_re_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;
  logic              cpu_ack_q;
  logic              ld_ack_q;
  logic              busy_q;
  logic              cpu_win;
  logic [3:0]        starve_inc;

  // CPU wins the arbitration unless the loader has been passed over too often.
  assign cpu_win    = cpu_req && !(ld_req && (starve_q == STARVE_LIM));
  assign starve_inc = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;

  // Access sequencer: grant, RAM strobe, read wait states and ack pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || ld_req) begin
            state_q <= ACCESS;
            busy_q  <= 1'b1;
            if (cpu_win) begin
              owner_q     <= 1'b0;
              ram_addr_q  <= cpu_addr;
              ram_wdata_q <= cpu_wdata;
              ram_we_q    <= cpu_we;
              ram_re_q    <= !cpu_we;
              starve_q    <= ld_req ? starve_inc : 4'd0;
            end else begin
              owner_q     <= 1'b1;
              ram_addr_q  <= ld_addr;
              ram_wdata_q <= ld_wdata;
              ram_we_q    <= ld_we;
              ram_re_q    <= !ld_we;
              starve_q    <= 4'd0;
            end
          end
        end
        ACCESS: begin
          if (ram_we_q) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= !owner_q;
            ld_ack_q    <= owner_q;
            state_q     <= DONE;
          end else if (RD_WAIT == 0) begin
            if (owner_q) ld_rdata_q <= ram_rdata;
            else         cpu_rdata_q <= ram_rdata;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= !owner_q;
            ld_ack_q    <= owner_q;
            state_q     <= DONE;
          end else begin
            wait_cnt_q <= WAIT_LAST;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            if (owner_q) ld_rdata_q <= ram_rdata;
            else         cpu_rdata_q <= ram_rdata;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= !owner_q;
            ld_ack_q    <= owner_q;
            state_q     <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        DONE: begin
          cpu_ack_q <= 1'b0;
          ld_ack_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance A uses RD_WAIT=1
// with a registered-read RAM model, instance B uses RD_WAIT=0 with a
// combinational-read RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b0;

  logic        a_cpu_req = 0, a_cpu_we = 0, a_ld_req = 0, a_ld_we = 0;
  logic [8:0]  a_cpu_addr = 0, a_ld_addr = 0;
  logic [31:0] a_cpu_wdata = 0, a_ld_wdata = 0;
  logic [31:0] a_cpu_rdata, a_ld_rdata, a_ram_wdata, a_ram_rdata;
  logic        a_cpu_ack, a_ld_ack, a_ram_we, a_ram_re, a_busy;
  logic [8:0]  a_ram_addr;

  logic        b_cpu_req = 0, b_cpu_we = 0, b_ld_req = 0, b_ld_we = 0;
  logic [8:0]  b_cpu_addr = 0, b_ld_addr = 0;
  logic [31:0] b_cpu_wdata = 0, b_ld_wdata = 0;
  logic [31:0] b_cpu_rdata, b_ld_rdata, b_ram_wdata, b_ram_rdata;
  logic        b_cpu_ack, b_ld_ack, b_ram_we, b_ram_re, b_busy;
  logic [8:0]  b_ram_addr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int viol_a = 0, viol_b = 0;
  int a_cpu_acks = 0, a_ld_acks = 0, a_we_cycles = 0;
  logic a_prev_cack = 0, a_prev_lack = 0, b_prev_cack = 0, b_prev_lack = 0;

  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .clr(clr),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .ld_req(a_ld_req), .ld_we(a_ld_we), .ld_addr(a_ld_addr),
    .ld_wdata(a_ld_wdata), .ld_rdata(a_ld_rdata), .ld_ack(a_ld_ack),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
    .ram_re(a_ram_re), .ram_rdata(a_ram_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(0), .STARVE_MAX(4)) dut_b (
    .clk(clk), .clr(clr),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr),
    .ld_wdata(b_ld_wdata), .ld_rdata(b_ld_rdata), .ld_ack(b_ld_ack),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
    .ram_re(b_ram_re), .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  // RAM A: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
    if (a_ram_re) a_ram_rdata <= mem_a[a_ram_addr];
  end

  // RAM B: data valid in the same cycle as the read strobe.
  always @(posedge clk) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
  end
  assign b_ram_rdata = mem_b[b_ram_addr];

  // Protocol monitor: exclusive strobes, exclusive acks, single-cycle acks,
  // zero address while idle; also counts acks and write-strobe cycles.
  always @(negedge clk) begin
    if (a_ram_we && a_ram_re) viol_a++;
    if (a_cpu_ack && a_ld_ack) viol_a++;
    if (a_cpu_ack && a_prev_cack) viol_a++;
    if (a_ld_ack && a_prev_lack) viol_a++;
    if (!a_busy && (a_ram_addr != 9'd0)) viol_a++;
    if (b_ram_we && b_ram_re) viol_b++;
    if (b_cpu_ack && b_ld_ack) viol_b++;
    if (b_cpu_ack && b_prev_cack) viol_b++;
    if (b_ld_ack && b_prev_lack) viol_b++;
    if (!b_busy && (b_ram_addr != 9'd0)) viol_b++;
    if (a_cpu_ack) a_cpu_acks++;
    if (a_ld_ack) a_ld_acks++;
    if (a_ram_we) a_we_cycles++;
    a_prev_cack = a_cpu_ack;
    a_prev_lack = a_ld_ack;
    b_prev_cack = b_cpu_ack;
    b_prev_lack = b_ld_ack;
  end

  // Drive one requester of one instance.
  task automatic drive(input int dut, input bit is_ld, input bit req, input bit we,
                       input logic [8:0] addr, input logic [31:0] data);
    if (dut == 0 && !is_ld) begin
      a_cpu_req = req; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = data;
    end else if (dut == 0) begin
      a_ld_req = req; a_ld_we = we; a_ld_addr = addr; a_ld_wdata = data;
    end else if (!is_ld) begin
      b_cpu_req = req; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = data;
    end else begin
      b_ld_req = req; b_ld_we = we; b_ld_addr = addr; b_ld_wdata = data;
    end
  endtask

  function automatic bit ack_of(input int dut, input bit is_ld);
    if (dut == 0) return is_ld ? a_ld_ack : a_cpu_ack;
    return is_ld ? b_ld_ack : b_cpu_ack;
  endfunction

  // One access; lat = negedges from raising req until ack is seen, -1 on timeout.
  task automatic do_access(input int dut, input bit is_ld, input bit we,
                           input logic [8:0] addr, input logic [31:0] data,
                           output int lat);
    lat = -1;
    @(negedge clk);
    drive(dut, is_ld, 1'b1, we, addr, data);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack_of(dut, is_ld)) begin
        lat = n;
        break;
      end
    end
    drive(dut, is_ld, 1'b0, 1'b0, 9'd0, 32'd0);
  endtask

  // Reset state of instance A.
  task automatic test_reset;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({a_ram_we, a_ram_re} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b expected 00", {a_ram_we, a_ram_re});
    else pass_cnt++;
    chk_cnt++;
    if (a_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", a_busy);
    else pass_cnt++;
    chk_cnt++;
    if ({a_cpu_ack, a_ld_ack} !== 2'b00) $display("[TB] FAIL reset_acks: got %b expected 00", {a_cpu_ack, a_ld_ack});
    else pass_cnt++;
    chk_cnt++;
    if (a_ram_addr !== 9'd0 || a_ram_wdata !== 32'd0) $display("[TB] FAIL reset_ram_bus: got %h/%h expected 0/0", a_ram_addr, a_ram_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (a_cpu_rdata !== 32'd0 || a_ld_rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", a_cpu_rdata, a_ld_rdata);
    else pass_cnt++;
    clr = 1'b1;
  endtask

  // CPU write then read, RD_WAIT=1.
  task automatic test_cpu_write_read;
    int lat;
    int we0;
    we0 = a_we_cycles;
    do_access(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, lat);
    chk_cnt++;
    if (lat !== 2) $display("[TB] FAIL cpu_write_latency: got %0d expected 2", lat);
    else pass_cnt++;
    chk_cnt++;
    if (a_we_cycles - we0 !== 1) $display("[TB] FAIL cpu_write_we_width: got %0d expected 1", a_we_cycles - we0);
    else pass_cnt++;
    do_access(0, 1'b0, 1'b0, 9'h010, 32'h0, lat);
    chk_cnt++;
    if (lat !== 3) $display("[TB] FAIL cpu_read_latency: got %0d expected 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (a_cpu_rdata !== 32'hDEADBEEF) $display("[TB] FAIL cpu_read_data: got %h expected deadbeef", a_cpu_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (a_ld_rdata !== 32'd0) $display("[TB] FAIL cpu_read_ld_hold: got %h expected 0", a_ld_rdata);
    else pass_cnt++;
  endtask

  // Both requesters held high from reset: loader gets every fifth grant.
  task automatic test_starvation;
    int got [10];
    int exp_owner [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int idx;
    int ld0;
    for (int i = 0; i < 10; i++) got[i] = -1;
    idx = 0;
    @(negedge clk);
    clr = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1, 9'h040, 32'h0000_0C0C);
    drive(0, 1'b1, 1'b1, 1'b1, 9'h041, 32'h0000_1D1D);
    @(negedge clk);
    ld0 = a_ld_acks;
    clr = 1'b1;
    for (int n = 0; n < 200 && idx < 10; n++) begin
      @(negedge clk);
      if (a_cpu_ack) begin got[idx] = 0; idx++; end
      else if (a_ld_ack) begin got[idx] = 1; idx++; end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk_cnt++;
      if (got[i] !== exp_owner[i]) $display("[TB] FAIL grant_order[%0d]: got %0d expected %0d (0=cpu 1=ld)", i, got[i], exp_owner[i]);
      else pass_cnt++;
    end
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (a_ld_acks - ld0 !== 2) $display("[TB] FAIL starve_ld_acks: got %0d expected 2", a_ld_acks - ld0);
    else pass_cnt++;
  endtask

  // Loader write/read with RD_WAIT=0 on instance B; CPU rdata must hold.
  task automatic test_loader_zero_wait;
    int lat;
    do_access(1, 1'b0, 1'b1, 9'h020, 32'hCAFEF00D, lat);
    do_access(1, 1'b0, 1'b0, 9'h020, 32'h0, lat);
    chk_cnt++;
    if (lat !== 2) $display("[TB] FAIL b_cpu_read_latency: got %0d expected 2", lat);
    else pass_cnt++;
    chk_cnt++;
    if (b_cpu_rdata !== 32'hCAFEF00D) $display("[TB] FAIL b_cpu_read_data: got %h expected cafef00d", b_cpu_rdata);
    else pass_cnt++;
    do_access(1, 1'b1, 1'b1, 9'h1FF, 32'h12345678, lat);
    chk_cnt++;
    if (lat !== 2) $display("[TB] FAIL ld_write_latency: got %0d expected 2", lat);
    else pass_cnt++;
    do_access(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat);
    chk_cnt++;
    if (lat !== 2) $display("[TB] FAIL ld_read_latency: got %0d expected 2", lat);
    else pass_cnt++;
    chk_cnt++;
    if (b_ld_rdata !== 32'h12345678) $display("[TB] FAIL ld_read_data: got %h expected 12345678", b_ld_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (b_cpu_rdata !== 32'hCAFEF00D) $display("[TB] FAIL ld_read_cpu_hold: got %h expected cafef00d", b_cpu_rdata);
    else pass_cnt++;
  endtask

  // Reset asserted during a read wait state aborts the access.
  task automatic test_reset_mid_access;
    int lat;
    int ack0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (a_ram_re !== 1'b1) $display("[TB] FAIL wait_re_held: got %b expected 1", a_ram_re);
    else pass_cnt++;
    ack0 = a_cpu_acks;
    clr = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    #1;
    chk_cnt++;
    if ({a_ram_re, a_busy} !== 2'b00) $display("[TB] FAIL abort_re_busy: got %b expected 00", {a_ram_re, a_busy});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (a_cpu_acks - ack0 !== 0) $display("[TB] FAIL abort_no_ack: got %0d expected 0", a_cpu_acks - ack0);
    else pass_cnt++;
    chk_cnt++;
    if (a_cpu_rdata !== 32'd0) $display("[TB] FAIL abort_rdata_cleared: got %h expected 0", a_cpu_rdata);
    else pass_cnt++;
    clr = 1'b1;
    do_access(0, 1'b0, 1'b0, 9'h010, 32'h0, lat);
    chk_cnt++;
    if (lat !== 3) $display("[TB] FAIL post_reset_latency: got %0d expected 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (a_cpu_rdata !== 32'hDEADBEEF) $display("[TB] FAIL post_reset_data: got %h expected deadbeef", a_cpu_rdata);
    else pass_cnt++;
  endtask

  // Request dropped (and fields scrambled) right after grant.
  task automatic test_req_drop;
    int lat;
    int ack0;
    @(negedge clk);
    ack0 = a_cpu_acks;
    drive(0, 1'b0, 1'b1, 1'b1, 9'h055, 32'hA5A50055);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 9'h066, 32'hFFFFFFFF);
    repeat (8) @(negedge clk);
    chk_cnt++;
    if (a_cpu_acks - ack0 !== 1) $display("[TB] FAIL drop_ack_count: got %0d expected 1", a_cpu_acks - ack0);
    else pass_cnt++;
    chk_cnt++;
    if (a_busy !== 1'b0) $display("[TB] FAIL drop_idle: got %b expected 0", a_busy);
    else pass_cnt++;
    do_access(0, 1'b0, 1'b0, 9'h055, 32'h0, lat);
    chk_cnt++;
    if (a_cpu_rdata !== 32'hA5A50055) $display("[TB] FAIL drop_latched_write: got %h expected a5a50055", a_cpu_rdata);
    else pass_cnt++;
  endtask

  // Accumulated protocol monitor results.
  task automatic test_invariants;
    chk_cnt++;
    if (viol_a !== 0) $display("[TB] FAIL protocol_a: got %0d violations expected 0", viol_a);
    else pass_cnt++;
    chk_cnt++;
    if (viol_b !== 0) $display("[TB] FAIL protocol_b: got %0d violations expected 0", viol_b);
    else pass_cnt++;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    a_ram_rdata = 32'd0;
    test_reset;
    test_cpu_write_read;
    test_starvation;
    test_loader_zero_wait;
    test_reset_mid_access;
    test_req_drop;
    repeat (2) @(negedge clk);
    test_invariants;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
